// File: rtl/seq101_rr_scheduler.sv
// Round-robin scheduler that shares one serial "101" Moore detector among NREQ requesters.
// Optional macro SEQ101_FIRSTPOS_EN adds res_hit / res_first_pos.
module seq101_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic [CW-1:0]           res_count
`ifdef SEQ101_FIRSTPOS_EN
    ,
    output logic                    res_hit,
    output logic [CW-1:0]           res_first_pos
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctl_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    ctl_t             state, state_next;
    det_t             det, det_next;
    logic [IDW-1:0]   rr_ptr, winner;
    logic             any_req, found, take;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    bit_cnt, match_cnt;
    logic             bit_in, match, last_bit;

`ifdef SEQ101_FIRSTPOS_EN
    logic             first_found;
    logic [CW-1:0]    first_pos;
`endif

    assign any_req  = |req;
    assign bit_in   = sr[WIDTH-1];
    assign last_bit = (bit_cnt == CW'(WIDTH - 1));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
                winner = IDW'((int'(rr_ptr) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        det_next = S0;
        case (det)
            S0:      det_next = bit_in ? S1 : S0;
            S1:      det_next = bit_in ? S1 : S2;
            S2:      det_next = bit_in ? S3 : S0;
            S3:      det_next = bit_in ? S1 : S2;
            default: det_next = S0;
        endcase
        match = (det_next == S3);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are masked while reset is high so an aborted word never surfaces.
    always_comb begin
        take = !sys_rst && (state == IDLE) && any_req;
        gnt  = '0;
        if (take) gnt[winner] = 1'b1;
        busy      = !sys_rst && ((state != IDLE) || any_req);
        res_valid = !sys_rst && (state == DONE);
    end

    // NOTE: all state updates use non-blocking assignments.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            rr_ptr    <= IDW'(NREQ - 1);
            det       <= S0;
            sr        <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
            res_id    <= '0;
            res_count <= '0;
`ifdef SEQ101_FIRSTPOS_EN
            first_found   <= 1'b0;
            first_pos     <= '0;
            res_hit       <= 1'b0;
            res_first_pos <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sr        <= data_in[int'(winner)*WIDTH +: WIDTH];
                        rr_ptr    <= winner;
                        bit_cnt   <= '0;
                        match_cnt <= '0;
                        det       <= S0;
`ifdef SEQ101_FIRSTPOS_EN
                        first_found <= 1'b0;
                        first_pos   <= '0;
`endif
                    end
                end
                SHIFT: begin
                    sr        <= {sr[WIDTH-2:0], 1'b0};
                    det       <= det_next;
                    bit_cnt   <= bit_cnt + 1'b1;
                    match_cnt <= match_cnt + CW'(match);
`ifdef SEQ101_FIRSTPOS_EN
                    if (match && !first_found) begin
                        first_found <= 1'b1;
                        first_pos   <= bit_cnt;
                    end
`endif
                    // Results are registered on the last bit so they hold until the next word.
                    if (last_bit) begin
                        res_id    <= rr_ptr;
                        res_count <= match_cnt + CW'(match);
`ifdef SEQ101_FIRSTPOS_EN
                        res_hit <= first_found || match;
                        if (first_found)
                            res_first_pos <= first_pos;
                        else if (match)
                            res_first_pos <= bit_cnt;
                        else
                            res_first_pos <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq101_rr_scheduler.sv
// Scoreboard bench for seq101_rr_scheduler: a requester model predicts grants and results,
// a separate monitor checks every res_valid against the queued expectation.
module tb_seq101_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = $clog2(NREQ);
    localparam int CW    = $clog2(WIDTH + 1);

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b1;
    logic [NREQ-1:0]       req     = '0;
    logic [NREQ*WIDTH-1:0] data_in = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy, res_valid;
    logic [IDW-1:0]        res_id;
    logic [CW-1:0]         res_count;
`ifdef SEQ101_FIRSTPOS_EN
    logic                  res_hit;
    logic [CW-1:0]         res_first_pos;
`endif

    seq101_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count)
`ifdef SEQ101_FIRSTPOS_EN
        ,
        .res_hit       (res_hit),
        .res_first_pos (res_first_pos)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int id;
        int count;
        int hit;
        int pos;
        int due;
    } exp_t;

    exp_t             sb[$];
    int               dut_grants[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    int               m_ptr  = NREQ - 1;
    int               next_free = 0;
    logic             rst_drv = 1'b1;
    logic             pend [NREQ];
    logic [WIDTH-1:0] word [NREQ];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: count overlapping "101" substrings, reading MSB first.
    function automatic int count101(input logic [WIDTH-1:0] w);
        int n = 0;
        for (int i = 0; i + 2 < WIDTH; i++)
            if (w[WIDTH-1-i] && !w[WIDTH-2-i] && w[WIDTH-3-i]) n++;
        return n;
    endfunction

    function automatic int first101(input logic [WIDTH-1:0] w);
        for (int i = 0; i + 2 < WIDTH; i++)
            if (w[WIDTH-1-i] && !w[WIDTH-2-i] && w[WIDTH-3-i]) return i + 2;
        return -1;
    endfunction

    function automatic int pick(input int ptr, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] cur_req();
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = pend[i];
        return r;
    endfunction

    task automatic drive();
        sys_rst = rst_drv;
        req     = cur_req();
        for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = word[i];
    endtask

    // One clock cycle: drive, predict and check gnt/busy at the negedge, release granted request.
    task automatic step();
        int w;
        int f;
        logic [NREQ-1:0] eg;
        logic eb;
        exp_t e;
        drive();
        @(negedge sys_clk);
        eg = '0;
        eb = 1'b0;
        w  = -1;
        if (!rst_drv) begin
            if (cyc >= next_free) w = pick(m_ptr, cur_req());
            if (w >= 0) eg[w] = 1'b1;
            eb = (cyc < next_free) || (cur_req() != '0);
        end
        check("gnt", int'(gnt), int'(eg));
        check("busy", int'(busy), int'(eb));
        for (int i = 0; i < NREQ; i++) if (gnt[i]) dut_grants.push_back(i);
        if (rst_drv) begin
            sb.delete();
            m_ptr     = NREQ - 1;
            next_free = 0;
        end else if (w >= 0) begin
            f       = first101(word[w]);
            e.id    = w;
            e.count = count101(word[w]);
            e.hit   = (f >= 0) ? 1 : 0;
            e.pos   = (f >= 0) ? f : 0;
            e.due   = cyc + WIDTH + 1;
            sb.push_back(e);
            m_ptr     = w;
            next_free = cyc + WIDTH + 2;
        end
        @(posedge sys_clk);
        #1;
        if (w >= 0 && !rst_drv) pend[w] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_drv = 1'b1;
        repeat (n) step();
        rst_drv = 1'b0;
    endtask

    task automatic wait_grant();
        int n0 = dut_grants.size();
        for (int i = 0; i < 100; i++) begin
            if (dut_grants.size() > n0) return;
            step();
        end
        if (dut_grants.size() == n0) check("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (cur_req() == '0 && sb.size() == 0) return;
            step();
        end
        check("drain_timeout", sb.size() + int'(cur_req()), 0);
    endtask

    task automatic offer(input int i, input logic [WIDTH-1:0] w);
        pend[i] = 1'b1;
        word[i] = w;
    endtask

    // Monitor: pops the scoreboard exactly when a result is due.
    always @(negedge sys_clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("res_valid", int'(res_valid), 1);
            check("res_id", int'(res_id), e.id);
            check("res_count", int'(res_count), e.count);
`ifdef SEQ101_FIRSTPOS_EN
            check("res_hit", int'(res_hit), e.hit);
            check("res_first_pos", int'(res_first_pos), e.pos);
`endif
        end else begin
            check("res_valid_idle", int'(res_valid), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            word[i] = '0;
        end
        do_reset(3);

        // Reset values of the registered result fields.
        @(negedge sys_clk);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_count", int'(res_count), 0);
`ifdef SEQ101_FIRSTPOS_EN
        check("rst_res_hit", int'(res_hit), 0);
        check("rst_res_first_pos", int'(res_first_pos), 0);
`endif
        @(posedge sys_clk);
        #1;

        // Single words with known match structure.
        offer(0, 8'hAA); wait_grant(); drain();
        offer(0, 8'b11011011); wait_grant(); drain();
        offer(0, 8'hFF); wait_grant(); drain();

        // All requesters held high: rotation starts after reset pointer.
        do_reset(1);
        g0 = dut_grants.size();
        for (int i = 0; i < NREQ; i++) offer(i, WIDTH'($urandom));
        for (int c = 0; c < 5 * (WIDTH + 2); c++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (!pend[i]) offer(i, WIDTH'($urandom));
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        check("rot_ngrants", dut_grants.size() - g0, 5);
        if (dut_grants.size() - g0 >= 5) begin
            check("rot_g0", dut_grants[g0],     0);
            check("rot_g1", dut_grants[g0 + 1], 1);
            check("rot_g2", dut_grants[g0 + 2], 2);
            check("rot_g3", dut_grants[g0 + 3], 3);
            check("rot_g4", dut_grants[g0 + 4], 0);
        end
        drain();

        // Back-to-back words must not carry detector state.
        offer(0, 8'b00000010); wait_grant();
        offer(0, 8'b10000000); wait_grant(); drain();

        // Reset mid-shift aborts the word and restores the pointer.
        offer(2, 8'hAA); wait_grant();
        offer(1, 8'h5A); offer(3, 8'hA5);
        repeat (3) step();
        do_reset(1);
        wait_grant();
        check("ptr_reset_grant", dut_grants[$], 1);
        drain();

        // Wrap-around: grant 2, then 0 while 2 is re-requested during SHIFT.
        offer(2, WIDTH'($urandom)); wait_grant();
        check("wrap_first", dut_grants[$], 2);
        repeat (2) step();
        offer(0, WIDTH'($urandom)); offer(2, WIDTH'($urandom));
        wait_grant();
        check("wrap_second", dut_grants[$], 0);
        drain();

        // Randomized traffic with occasional withdrawals.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    case ($urandom_range(3))
                        0:       offer(i, 8'hAA);
                        1:       offer(i, 8'hB5);
                        default: offer(i, WIDTH'($urandom));
                    endcase
                end else if (pend[i] && $urandom_range(31) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i]) begin
                    word[i] = WIDTH'($urandom);
                end
            end
            step();
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drain();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
